rnn_mem_arb: RTL and testbench
==============================

RNN_MEM_ARB -- requirements
Module: rnn_mem_arb

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- wf_req  in  1  weight-fetch requester: request.
- wf_wr  in  1  weight-fetch: 1 = write, 0 = read.
- wf_lock  in  1  weight-fetch: hold grant for burst.
- wf_sel  in  3  weight-fetch: memory region select.
- wf_addr  in  17  weight-fetch: word address.
- wf_wdata  in  20  weight-fetch: write data.
- wf_gnt  out  1  weight-fetch: grant, combinational, same cycle as accepted req.
- wf_rvalid  out  1  weight-fetch: read data valid on rdata.
- hs_req, hs_wr, hs_lock, hs_sel[2:0], hs_addr[16:0], hs_wdata[19:0], hs_gnt, hs_rvalid: hidden-state requester, same widths and meanings as the wf_* ports.
- rdata  out  20  read data, shared by both requesters; equals mdata_r.
- mce  out  1  memory enable, registered.
- maddr  out  17  memory address, registered.
- msel  out  3  memory region select, registered.
- mdata_w  out  20  memory write data, registered.
- mdata_r  in  20  memory read data; valid the cycle after mce/maddr are presented.

Function
REQ-003 SHALL accept at most one request per cycle; x_gnt=1 iff x_req=1 and x is chosen; accepted request is the handshake (req&gnt).
REQ-004 SHALL arbitrate round-robin: a single requesting side wins; if both request, the side not granted last wins; last-granted pointer resets to hs, so wf wins first contention.
REQ-005 SHALL, if last grant went to x, x_lock=1, x_req=1 and lock count <64, grant x again regardless of other side.
REQ-006 SHALL count consecutive locked grants (7-bit); after 64, if other side requests, other side SHALL be granted exactly once and the counter SHALL clear.
REQ-007 SHALL clear lock counter on any grant to the other side, or on any cycle with x_lock=0 or no grant.
REQ-008 SHALL at the edge ending grant cycle N register mce=1, maddr/msel/mdata_w from granted side; cycle N+1 presents the command.
REQ-009 SHALL drive mce=0 in any cycle following a cycle with no grant; maddr/msel/mdata_w hold their last values then.
REQ-010 SHALL for a read granted in cycle N assert x_rvalid for exactly cycle N+2, with rdata=mdata_r; writes produce no rvalid.
REQ-011 SHALL track the read pipeline with a 2-stage {valid, owner} shift register; back-to-back reads SHALL return in grant order, one per cycle, no bubbles.
REQ-012 SHALL never assert wf_rvalid and hs_rvalid in the same cycle.
REQ-013 SHALL treat x_wr, x_sel, x_addr, x_wdata as don't-care when x_req=0.

Reset
REQ-014 SHALL, on reset=0 at an edge, set mce=0, maddr=0, msel=0, mdata_w=0, pipeline valids=0, lock counter=0, pointer=hs.
REQ-015 SHALL force wf_gnt=hs_gnt=0 combinationally while reset=0.
REQ-016 SHALL discard in-flight reads on reset mid-operation: no rvalid in the cycles after reset; rvalid resumes only for reads granted after reset=1.

Configuration
REQ-017 SHALL support macro RNN_MEM_ARB_WPRIO_EN: when defined, on contention a write request SHALL beat a read request, overriding round-robin and any active lock; write vs write or read vs read uses REQ-004..006.
REQ-018 SHALL, without RNN_MEM_ARB_WPRIO_EN, ignore x_wr for arbitration entirely.

Verification
REQ-019 Reset 0 for 2 cycles with both req=1 -> gnt=0, mce=0, maddr=0, no rvalid; first cycle after release wf_gnt=1.
REQ-020 Both read every cycle, no lock -> grants alternate wf,hs,wf,hs; mce=1 continuously; rvalid alternates two cycles behind grants; rdata matches mdata_r.
REQ-021 wf_lock=1 and wf_req=1 held 70 cycles, hs_req=1 -> 64 wf grants, 1 hs grant, counter cleared, wf resumes locked burst.
REQ-022 wf read to addr 0x00123, sel 3'b010, granted cycle 5 -> maddr=0x00123, msel=3'b010, mce=1 in cycle 6; wf_rvalid=1 in cycle 7 only.
REQ-023 hs write addr 0x1FFFF, wdata 0xFFFFF, reset pulled low in cycle after wf read grant -> write reaches memory, wf_rvalid never asserted.
REQ-024 With RNN_MEM_ARB_WPRIO_EN, wf_lock read burst active, hs_wr=1 req -> hs_gnt=1 that cycle; without macro, hs waits until lock count reaches 64.

Source files
------------

// File: rtl/rnn_mem_arb_if.sv
// Bus bundle between the RNN requesters (weight-fetch, hidden-state) and the
// single-port memory; the arbiter takes the slave side.
interface rnn_mem_arb_if;
    logic        wf_req;
    logic        wf_wr;
    logic        wf_lock;
    logic [2:0]  wf_sel;
    logic [16:0] wf_addr;
    logic [19:0] wf_wdata;
    logic        wf_gnt;
    logic        wf_rvalid;

    logic        hs_req;
    logic        hs_wr;
    logic        hs_lock;
    logic [2:0]  hs_sel;
    logic [16:0] hs_addr;
    logic [19:0] hs_wdata;
    logic        hs_gnt;
    logic        hs_rvalid;

    logic [19:0] rdata;
    logic        mce;
    logic [16:0] maddr;
    logic [2:0]  msel;
    logic [19:0] mdata_w;
    logic [19:0] mdata_r;

    // A request is accepted in the cycle where x_req and x_gnt are both high;
    // x_gnt is combinational and x_rvalid is a single-cycle strobe (no ready).
    modport slave (
        input  wf_req, wf_wr, wf_lock, wf_sel, wf_addr, wf_wdata,
        input  hs_req, hs_wr, hs_lock, hs_sel, hs_addr, hs_wdata,
        input  mdata_r,
        output wf_gnt, wf_rvalid, hs_gnt, hs_rvalid,
        output rdata, mce, maddr, msel, mdata_w
    );

    modport master (
        output wf_req, wf_wr, wf_lock, wf_sel, wf_addr, wf_wdata,
        output hs_req, hs_wr, hs_lock, hs_sel, hs_addr, hs_wdata,
        output mdata_r,
        input  wf_gnt, wf_rvalid, hs_gnt, hs_rvalid,
        input  rdata, mce, maddr, msel, mdata_w
    );
endinterface

// File: rtl/rnn_mem_arb.sv
// Two-requester round-robin memory arbiter with lock bursts and a 2-stage read return pipe.
// Optional macro RNN_MEM_ARB_WPRIO_EN: on contention a write beats a read.
module rnn_mem_arb (
    input  logic         clk,
    input  logic         reset,
    rnn_mem_arb_if.slave bus
);
    localparam logic       SIDE_WF  = 1'b0;
    localparam logic       SIDE_HS  = 1'b1;
    localparam logic [6:0] LOCK_MAX = 7'd64;

    logic        last_q, last_d;
    logic [6:0]  lock_cnt_q, lock_cnt_d;
    logic        mce_q;
    logic [16:0] maddr_q;
    logic [2:0]  msel_q;
    logic [19:0] mdata_w_q;
    logic [1:0]  pipe_v_q;
    logic [1:0]  pipe_own_q;

    logic wf_hold, hs_hold;
    logic pick, any_gnt, pick_lock, pick_wr;

    always_comb begin
        wf_hold = (last_q == SIDE_WF) && bus.wf_lock && bus.wf_req && (lock_cnt_q < LOCK_MAX);
        hs_hold = (last_q == SIDE_HS) && bus.hs_lock && bus.hs_req && (lock_cnt_q < LOCK_MAX);
        pick    = SIDE_WF;
        if (bus.wf_req && bus.hs_req) begin
            // A live lock keeps the last winner; otherwise (including an exhausted lock) the other side goes.
            if (wf_hold || hs_hold)
                pick = last_q;
            else
                pick = ~last_q;
`ifdef RNN_MEM_ARB_WPRIO_EN
            if (bus.wf_wr != bus.hs_wr)
                pick = bus.hs_wr ? SIDE_HS : SIDE_WF;
`endif
        end else if (bus.hs_req) begin
            pick = SIDE_HS;
        end
        any_gnt   = (bus.wf_req || bus.hs_req) && reset;
        pick_lock = (pick == SIDE_HS) ? bus.hs_lock : bus.wf_lock;
        pick_wr   = (pick == SIDE_HS) ? bus.hs_wr   : bus.wf_wr;

        lock_cnt_d = 7'd0;
        if (any_gnt && pick_lock) begin
            if (pick != last_q)
                lock_cnt_d = 7'd1;
            else if (lock_cnt_q < LOCK_MAX)
                lock_cnt_d = lock_cnt_q + 7'd1;
            else
                lock_cnt_d = lock_cnt_q;
        end
        last_d = any_gnt ? pick : last_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q     <= SIDE_HS;
            lock_cnt_q <= 7'd0;
            mce_q      <= 1'b0;
            maddr_q    <= 17'd0;
            msel_q     <= 3'd0;
            mdata_w_q  <= 20'd0;
            pipe_v_q   <= 2'b00;
            pipe_own_q <= 2'b00;
        end else begin
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            mce_q      <= any_gnt;
            if (any_gnt) begin
                maddr_q   <= (pick == SIDE_HS) ? bus.hs_addr  : bus.wf_addr;
                msel_q    <= (pick == SIDE_HS) ? bus.hs_sel   : bus.wf_sel;
                mdata_w_q <= (pick == SIDE_HS) ? bus.hs_wdata : bus.wf_wdata;
            end
            pipe_v_q   <= {pipe_v_q[0], any_gnt && !pick_wr};
            pipe_own_q <= {pipe_own_q[0], pick};
        end
    end

    assign bus.wf_gnt    = any_gnt && (pick == SIDE_WF);
    assign bus.hs_gnt    = any_gnt && (pick == SIDE_HS);
    assign bus.wf_rvalid = reset && pipe_v_q[1] && (pipe_own_q[1] == SIDE_WF);
    assign bus.hs_rvalid = reset && pipe_v_q[1] && (pipe_own_q[1] == SIDE_HS);
    assign bus.rdata     = bus.mdata_r;
    assign bus.mce       = mce_q;
    assign bus.maddr     = maddr_q;
    assign bus.msel      = msel_q;
    assign bus.mdata_w   = mdata_w_q;
endmodule

// File: tb/tb_rnn_mem_arb.sv
// Directed bench for rnn_mem_arb: reset, alternation, lock burst, read latency,
// reset mid-flight and the optional write-priority build.
module tb_rnn_mem_arb;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    rnn_mem_arb_if bus();

    rnn_mem_arb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] mem_f(input logic [16:0] a);
        return {3'b101, a} ^ 20'h0A5A5;
    endfunction

    // Memory returns data the cycle after the address is presented.
    always @(posedge clk) bus.mdata_r <= mem_f(bus.maddr);

    // Expected-state model built from the hand-written grant sequence.
    logic        em_known;
    logic        em_mce;
    logic [16:0] em_maddr;
    logic [2:0]  em_msel;
    logic [19:0] em_wdata;
    logic        e1_v, e1_own, e2_v, e2_own;
    logic [16:0] e1_addr, e2_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_wf(input logic req, input logic wr, input logic lock,
                          input logic [2:0] sel, input logic [16:0] addr, input logic [19:0] wdata);
        bus.wf_req = req; bus.wf_wr = wr; bus.wf_lock = lock;
        bus.wf_sel = sel; bus.wf_addr = addr; bus.wf_wdata = wdata;
    endtask

    task automatic set_hs(input logic req, input logic wr, input logic lock,
                          input logic [2:0] sel, input logic [16:0] addr, input logic [19:0] wdata);
        bus.hs_req = req; bus.hs_wr = wr; bus.hs_lock = lock;
        bus.hs_sel = sel; bus.hs_addr = addr; bus.hs_wdata = wdata;
    endtask

    task automatic idle();
        set_wf(1'b0, 1'b0, 1'b0, 3'd0, 17'd0, 20'd0);
        set_hs(1'b0, 1'b0, 1'b0, 3'd0, 17'd0, 20'd0);
    endtask

    // Called just after a falling edge with inputs set; checks this cycle, then advances.
    task automatic step(input logic ewf, input logic ehs);
        #1;
        chk("wf_gnt", bus.wf_gnt, ewf);
        chk("hs_gnt", bus.hs_gnt, ehs);
        if (em_known) begin
            chk("mce", bus.mce, em_mce);
            chk("maddr", bus.maddr, em_maddr);
            chk("msel", bus.msel, em_msel);
            chk("mdata_w", bus.mdata_w, em_wdata);
            chk("wf_rvalid", bus.wf_rvalid, reset & e2_v & ~e2_own);
            chk("hs_rvalid", bus.hs_rvalid, reset & e2_v & e2_own);
            if (reset && e2_v) chk("rdata", bus.rdata, mem_f(e2_addr));
        end
        if (!reset) begin
            em_known = 1'b1;
            em_mce = 1'b0; em_maddr = 17'd0; em_msel = 3'd0; em_wdata = 20'd0;
            e1_v = 1'b0; e2_v = 1'b0; e1_own = 1'b0; e2_own = 1'b0;
            e1_addr = 17'd0; e2_addr = 17'd0;
        end else begin
            e2_v = e1_v; e2_own = e1_own; e2_addr = e1_addr;
            em_mce = ewf | ehs;
            if (ewf) begin
                em_maddr = bus.wf_addr; em_msel = bus.wf_sel; em_wdata = bus.wf_wdata;
            end else if (ehs) begin
                em_maddr = bus.hs_addr; em_msel = bus.hs_sel; em_wdata = bus.hs_wdata;
            end
            e1_v    = (ewf & ~bus.wf_wr) | (ehs & ~bus.hs_wr);
            e1_own  = ehs;
            e1_addr = ewf ? bus.wf_addr : bus.hs_addr;
        end
        @(negedge clk);
    endtask

    int n_wait;

    initial begin
        total = 0;
        bad = 0;
        em_known = 1'b0;
        em_mce = 1'b0; em_maddr = 17'd0; em_msel = 3'd0; em_wdata = 20'd0;
        e1_v = 1'b0; e2_v = 1'b0; e1_own = 1'b0; e2_own = 1'b0;
        e1_addr = 17'd0; e2_addr = 17'd0;
        reset = 1'b0;
        idle();
        @(negedge clk);

        // Reset held two cycles with both requesting: no grants, outputs cleared.
        set_wf(1'b1, 1'b0, 1'b0, 3'd1, 17'h00100, 20'h11111);
        set_hs(1'b1, 1'b0, 1'b0, 3'd2, 17'h00200, 20'h22222);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        reset = 1'b1;

        // Both read every cycle: wf first, then strict alternation.
        for (int i = 0; i < 8; i++) begin
            set_wf(1'b1, 1'b0, 1'b0, 3'(i), 17'h00100 + 17'(i), 20'h10000 + 20'(i));
            set_hs(1'b1, 1'b0, 1'b0, 3'(7 - i), 17'h00200 + 17'(i), 20'h20000 + 20'(i));
            step((i % 2) == 0, (i % 2) == 1);
        end
        idle();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Single wf read: command next cycle, rvalid two cycles later only.
        set_wf(1'b1, 1'b0, 1'b0, 3'b010, 17'h00123, 20'h0ABCD);
        step(1'b1, 1'b0);
        idle();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // hs write at the top address, wf read, then reset discards the read.
        set_hs(1'b1, 1'b1, 1'b0, 3'b111, 17'h1FFFF, 20'hFFFFF);
        step(1'b0, 1'b1);
        idle();
        set_wf(1'b1, 1'b0, 1'b0, 3'b001, 17'h00055, 20'h00000);
        step(1'b1, 1'b0);
        reset = 1'b0;
        set_wf(1'b1, 1'b0, 1'b0, 3'b001, 17'h00066, 20'h00000);
        set_hs(1'b1, 1'b0, 1'b0, 3'b001, 17'h00077, 20'h00000);
        step(1'b0, 1'b0);
        reset = 1'b1;
        idle();
        step(1'b0, 1'b0);
        set_wf(1'b1, 1'b0, 1'b0, 3'b100, 17'h00abc, 20'h00000);
        step(1'b1, 1'b0);
        idle();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Lock burst: 64 wf grants, one hs grant, then wf resumes.
        reset = 1'b0;
        step(1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 70; i++) begin
            set_wf(1'b1, 1'b0, 1'b1, 3'd3, 17'h01000 + 17'(i), 20'd0);
            set_hs(1'b1, 1'b0, 1'b0, 3'd4, 17'h02000 + 17'(i), 20'd0);
            step(i != 64, i == 64);
        end
        idle();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // hs write against a live wf read lock.
        reset = 1'b0;
        step(1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_wf(1'b1, 1'b0, 1'b1, 3'd5, 17'h03000 + 17'(i), 20'd0);
            step(1'b1, 1'b0);
        end
`ifdef RNN_MEM_ARB_WPRIO_EN
        n_wait = 0;
`else
        n_wait = 61;
`endif
        for (int i = 0; i <= n_wait; i++) begin
            set_wf(1'b1, 1'b0, 1'b1, 3'd5, 17'h03100 + 17'(i), 20'd0);
            set_hs(1'b1, 1'b1, 1'b0, 3'd6, 17'h04000, 20'h0BEEF);
            step(i != n_wait, i == n_wait);
        end
        set_hs(1'b0, 1'b0, 1'b0, 3'd0, 17'd0, 20'd0);
        step(1'b1, 1'b0);
        idle();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
